// File: rtl/program_sequencer_pkg.sv
// Shared types for the calculation CPU: opcodes, condition codes and
// sequencer states, plus small decode helpers.
package cpu_pkg;

    localparam int unsigned INST_W    = 8;
    localparam int unsigned RETIRED_W = 16;

    typedef enum logic [1:0] {
        OP_IMM   = 2'b00,
        OP_ARITH = 2'b01,
        OP_COPY  = 2'b10,
        OP_COND  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_EQ     = 3'b001,
        COND_LT     = 3'b010,
        COND_LE     = 3'b011,
        COND_ALWAYS = 3'b100,
        COND_NE     = 3'b101,
        COND_GE     = 3'b110,
        COND_GT     = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } seq_state_e;

    // Opcode field of an instruction byte
    function automatic opcode_e inst_opcode(input logic [INST_W-1:0] inst);
        return opcode_e'(inst[7:6]);
    endfunction

    // Condition-code field of an instruction byte
    function automatic cond_e inst_cond(input logic [INST_W-1:0] inst);
        return cond_e'(inst[2:0]);
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Program-memory read channel.
//   mem_req   : read request, held until accepted (master -> slave)
//   mem_addr  : read address                      (master -> slave)
//   mem_valid : mem_data valid this cycle         (slave -> master)
//   mem_data  : instruction byte                  (slave -> master)
interface program_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [7:0]        mem_data;

    modport master (output mem_req, output mem_addr, input mem_valid, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_valid, output mem_data);
endinterface

// File: rtl/program_sequencer_condition_unit.sv
// Combinational branch-condition evaluator.
//   code  : condition code (cond_e)
//   val   : signed condition operand
//   taken : 1 when the condition holds for val
module condition_unit
    import cpu_pkg::*;
(
    input  cond_e              code,
    input  logic signed [7:0]  val,
    output logic               taken
);

    always_comb begin
        taken = 1'b0;
        case (code)
            COND_NEVER:  taken = 1'b0;
            COND_EQ:     taken = (val == 8'sd0);
            COND_LT:     taken = (val <  8'sd0);
            COND_LE:     taken = (val <= 8'sd0);
            COND_ALWAYS: taken = 1'b1;
            COND_NE:     taken = (val != 8'sd0);
            COND_GE:     taken = (val >= 8'sd0);
            COND_GT:     taken = (val >  8'sd0);
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/issue controller: holds the pc, fetches one instruction byte per
// step, strobes it to the datapath and resolves condition instructions.
//   clk, rst    : clock, synchronous active-high reset
//   run         : start / keep running, sampled at instruction boundaries
//   mem         : program-memory read channel (master side)
//   inst        : registered instruction; inst_valid is the execute strobe
//   cond_val    : signed condition operand (datapath reg3)
//   jump_target : jump destination (datapath reg0)
//   pc, halted, retired : program counter, sticky halt, saturating count
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PROG_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    program_sequencer_if.master  mem,
    output logic [INST_W-1:0]    inst,
    output logic                 inst_valid,
    input  logic [7:0]           cond_val,
    input  logic [7:0]           jump_target,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic [RETIRED_W-1:0] retired
);

    localparam logic [RETIRED_W-1:0] RETIRED_MAX = '1;

    seq_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_req_q, mem_req_d;
    logic [INST_W-1:0]    inst_q, inst_d;
    logic                 inst_valid_q, inst_valid_d;
    logic                 halted_q, halted_d;
    logic [RETIRED_W-1:0] retired_q, retired_d;

    logic                 cond_taken_c;
    logic                 jump_c;
    logic [ADDR_W-1:0]    pc_next_c;

    condition_unit u_cond (
        .code  (inst_cond(inst_q)),
        .val   (cond_val),
        .taken (cond_taken_c)
    );

    // Sequential successor of the instruction currently in EXEC
    assign jump_c    = (inst_opcode(inst_q) == OP_COND) && cond_taken_c;
    assign pc_next_c = jump_c ? ADDR_W'(jump_target) : pc_q + ADDR_W'(1);

    // Next state; registered outputs are decoded from the state being entered
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        inst_d     = inst_q;
        retired_d  = retired_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_FETCH;
                    mem_addr_d = pc_q;
                end
            end
            S_FETCH: begin
                if (mem.mem_valid) begin
                    inst_d  = mem.mem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d      = pc_next_c;
                retired_d = (retired_q == RETIRED_MAX) ? retired_q
                                                       : retired_q + RETIRED_W'(1);
                // 32-bit compare so PROG_LEN = 2**ADDR_W never halts
                if (32'(pc_next_c) >= PROG_LEN) begin
                    state_d = S_HALT;
                end else if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_FETCH;
                    mem_addr_d = pc_next_c;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        mem_req_d    = (state_d == S_FETCH);
        inst_valid_d = (state_d == S_EXEC);
        halted_d     = (state_d == S_HALT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            retired_q    <= retired_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign inst         = inst_q;
    assign inst_valid   = inst_valid_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer. Three instances with
// PROG_LEN 3 / 64 / 256 share one program image; each has its own
// wait-state memory responder. A scoreboard queue holds the expected
// instruction and following pc for every execute strobe.
module tb_program_sequencer;
    import cpu_pkg::*;

    localparam int unsigned N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst_a, run_a, iv_a, halt_a, req_a;
    logic [N-1:0][7:0]  cond_a, jt_a, inst_a, pc_a, addr_a;
    logic [N-1:0][15:0] ret_a;
    int unsigned        waits_a [N];
    logic [7:0]         prog [256];

    typedef struct packed {
        logic [7:0] inst;
        logic [7:0] pc_next;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         sel      = 0;
    bit         mon_en   = 1'b0;
    bit         pend     = 1'b0;
    logic [7:0] pend_pc;
    logic [7:0] vals [5] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};

    for (genvar g = 0; g < N; g++) begin : g_dut
        program_sequencer_if #(.ADDR_W(8)) bus ();
        int unsigned wcnt;

        program_sequencer #(
            .ADDR_W   (8),
            .PROG_LEN ((g == 0) ? 3 : (g == 1) ? 64 : 256)
        ) u_dut (
            .clk         (clk),
            .rst         (rst_a[g]),
            .run         (run_a[g]),
            .mem         (bus),
            .inst        (inst_a[g]),
            .inst_valid  (iv_a[g]),
            .cond_val    (cond_a[g]),
            .jump_target (jt_a[g]),
            .pc          (pc_a[g]),
            .halted      (halt_a[g]),
            .retired     (ret_a[g])
        );

        assign req_a[g]  = bus.mem_req;
        assign addr_a[g] = bus.mem_addr;

        // Memory answers after waits_a[g] request cycles
        always @(negedge clk) begin
            if (!bus.mem_req) begin
                bus.mem_valid = 1'b0;
                wcnt          = 0;
            end else begin
                bus.mem_valid = (wcnt == waits_a[g]);
                bus.mem_data  = prog[bus.mem_addr];
                wcnt          = bus.mem_valid ? 0 : wcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] i, input logic [7:0] p);
        exp_t e;
        e.inst    = i;
        e.pc_next = p;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut(input int i);
        rst_a[i] = 1'b1;
        run_a[i] = 1'b0;
        tick(2);
        rst_a[i] = 1'b0;
    endtask

    task automatic wait_iv(input int i, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (iv_a[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("iv_wait", 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_vals(input int i, input string pfx);
        chk({pfx, "_inst"},    32'(inst_a[i]), 32'h00);
        chk({pfx, "_iv"},      32'(iv_a[i]),   32'd0);
        chk({pfx, "_halted"},  32'(halt_a[i]), 32'd0);
        chk({pfx, "_retired"}, 32'(ret_a[i]),  32'd0);
        chk({pfx, "_pc"},      32'(pc_a[i]),   32'd0);
        chk({pfx, "_req"},     32'(req_a[i]),  32'd0);
        chk({pfx, "_addr"},    32'(addr_a[i]), 32'd0);
    endtask

    function automatic bit cond_model(input logic [2:0] c, input logic [7:0] v);
        logic signed [7:0] s;
        s = signed'(v);
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return s == 0;
            3'd2:    return s < 0;
            3'd3:    return s <= 0;
            3'd4:    return 1'b1;
            3'd5:    return s != 0;
            3'd6:    return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // Scoreboard: pop on each strobe, check pc one cycle later
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                chk("pc_next", 32'(pc_a[sel]), 32'(pend_pc));
                pend = 1'b0;
            end
            if (iv_a[sel]) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst", 32'(inst_a[sel]), 32'(mon_e.inst));
                    pend_pc = mon_e.pc_next;
                    pend    = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nreq;
        bit stable;
        bit ok;
        logic [7:0] ib;

        rst_a = '1;
        run_a = '0;
        cond_a = '0;
        jt_a = '0;
        for (int i = 0; i < N; i++) waits_a[i] = 0;
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        tick(3);
        rst_a = '0;
        tick(1);

        // Reset state
        chk_reset_vals(1, "reset");

        // Zero-wait three-instruction program, PROG_LEN = 3
        sel = 0;
        mon_en = 1'b1;
        prog[0] = 8'h05; prog[1] = 8'h44; prog[2] = 8'h83;
        push(8'h05, 8'h01); push(8'h44, 8'h02); push(8'h83, 8'h03);
        run_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("iv_cycle%0d", k), 32'(iv_a[0]), 32'((k == 2) || (k == 4) || (k == 6)));
        end
        chk("p3_halted",  32'(halt_a[0]), 32'd1);
        chk("p3_pc",      32'(pc_a[0]),   32'd3);
        chk("p3_retired", 32'(ret_a[0]),  32'd3);
        tick(3);
        chk("p3_no_req",  32'(req_a[0]),  32'd0);
        run_a[0] = 1'b0;

        // Three wait states: address held for four FETCH cycles
        sel = 1;
        waits_a[1] = 3;
        reset_dut(1);
        prog[0] = 8'h11; prog[1] = 8'h52; prog[2] = 8'h9A;
        push(8'h11, 8'h01); push(8'h52, 8'h02); push(8'h9A, 8'h03);
        run_a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0; stable = 1'b1; ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (iv_a[1]) begin
                    ok = 1'b1;
                    break;
                end
                if (req_a[1]) begin
                    n++;
                    if (addr_a[1] !== 8'(i)) stable = 1'b0;
                end
            end
            if (i == 2) run_a[1] = 1'b0;
            chk($sformatf("fetch_cycles%0d", i), 32'(n), 32'd4);
            chk($sformatf("addr_hold%0d", i), 32'(stable), 32'd1);
            chk($sformatf("ws_iv%0d", i), 32'(ok), 32'd1);
        end
        tick(3);
        chk("ws_idle", 32'(g_dut[1].u_dut.state_q), 32'(S_IDLE));
        chk("ws_pc",   32'(pc_a[1]), 32'd3);

        // Condition sweep, jump_target = 0x20
        waits_a[1] = 0;
        jt_a[1] = 8'h20;
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < 8; c++) begin
                reset_dut(1);
                cond_a[1] = vals[v];
                ib = 8'hC0 | 8'(c);
                prog[0] = ib;
                push(ib, cond_model(3'(c), vals[v]) ? 8'h20 : 8'h01);
                run_a[1] = 1'b1;
                wait_iv(1, 10);
                run_a[1] = 1'b0;
                tick(1);
            end
        end

        // Jump beyond PROG_LEN halts without another fetch
        reset_dut(1);
        prog[0] = 8'hC4;
        jt_a[1] = 8'h50;
        push(8'hC4, 8'h50);
        run_a[1] = 1'b1;
        wait_iv(1, 10);
        tick(1);
        chk("oob_halted", 32'(halt_a[1]), 32'd1);
        nreq = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req_a[1]) nreq++;
        end
        chk("oob_no_req", 32'(nreq), 32'd0);
        chk("oob_sticky", 32'(halt_a[1]), 32'd1);

        // rst leaves HALT; then run dropped mid-FETCH with two waits
        reset_dut(1);
        chk("halt_rst_halted", 32'(halt_a[1]), 32'd0);
        chk("halt_rst_pc",     32'(pc_a[1]),   32'd0);
        waits_a[1] = 2;
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'h04;
        push(8'h01, 8'h01);
        run_a[1] = 1'b1;
        tick(1);
        chk("drop_req", 32'(req_a[1]), 32'd1);
        run_a[1] = 1'b0;
        wait_iv(1, 10);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (iv_a[1]) n++;
        end
        chk("drop_extra_iv", 32'(n), 32'd0);
        chk("drop_idle",     32'(g_dut[1].u_dut.state_q), 32'(S_IDLE));
        chk("drop_req_off",  32'(req_a[1]), 32'd0);
        chk("drop_pc",       32'(pc_a[1]),  32'd1);

        // rst during FETCH abandons the request
        waits_a[1] = 3;
        run_a[1] = 1'b1;
        tick(2);
        chk("rstf_req",  32'(req_a[1]),  32'd1);
        chk("rstf_addr", 32'(addr_a[1]), 32'd1);
        rst_a[1] = 1'b1;
        run_a[1] = 1'b0;
        tick(1);
        chk_reset_vals(1, "rstf");
        rst_a[1] = 1'b0;
        tick(1);

        // PROG_LEN = 256: pc wraps FF -> 00 without halting
        sel = 2;
        jt_a[2] = 8'hFE;
        prog[0] = 8'hC4; prog[8'hFE] = 8'h01; prog[8'hFF] = 8'h02;
        push(8'hC4, 8'hFE); push(8'h01, 8'hFF); push(8'h02, 8'h00); push(8'hC4, 8'hFE);
        run_a[2] = 1'b1;
        for (int k = 0; k < 4; k++) wait_iv(2, 10);
        run_a[2] = 1'b0;
        tick(1);
        chk("wrap_halted",  32'(halt_a[2]), 32'd0);
        chk("wrap_retired", 32'(ret_a[2]),  32'd4);

        // retired preloaded near saturation, then the loop keeps running
        force g_dut[2].u_dut.retired_q = 16'hFFFD;
        tick(1);
        release g_dut[2].u_dut.retired_q;
        chk("sat_preload", 32'(ret_a[2]), 32'hFFFD);
        push(8'h01, 8'hFF); push(8'h02, 8'h00); push(8'hC4, 8'hFE);
        push(8'h01, 8'hFF); push(8'h02, 8'h00);
        run_a[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_iv(2, 10);
            if (k == 5) run_a[2] = 1'b0;
            chk($sformatf("sat_retired%0d", k), 32'(ret_a[2]),
                (k == 1) ? 32'hFFFD : (k == 2) ? 32'hFFFE : 32'hFFFF);
        end
        tick(2);
        chk("sat_hold",    32'(ret_a[2]),  32'hFFFF);
        chk("sat_halted",  32'(halt_a[2]), 32'd0);
        chk("sb_drain",    32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
